full_hash: RTL and testbench
============================

Name: full_hash

Overview:
- Streaming 32-bit hash engine that consumes an arbitrary-length byte message.
- A software/testbench producer feeds it one byte at a time over a ready/valid-style handshake, then signals end of file.
- The block appends the message length, applies a final avalanche mix, and presents the 32-bit digest with a ready flag.
- It sits between a byte source (file reader) and a digest consumer.

Parameters:
- none (all constants fixed; listed under Behaviour)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  synchronous reset, active-high (asserted when 1); name kept per codebase convention
- start  input  1  one-cycle pulse; begins a new hash session from IDLE
- Byte  input  8  message byte, sampled when a byte is accepted
- End_of_File  input  1  marks end of message; sampled while F_rtr=1
- F_dr  input  1  producer "data ready": Byte is valid
- R_h  output  32 [0:31]  digest; R_h[0] is MSB
- F_rtr  output  1  "ready to receive": block accepts a byte or EOF this cycle
- H_ready  output  1  digest valid

Behaviour:
- Single clock domain; outputs decoded from registered state (no combinational input-to-output path).
- Reset (rst_n=1 at rising edge): state=IDLE, H=0, count=0, F_rtr=0, H_ready=0, R_h=0. Reset has priority over every other input. Reset mid-session aborts it; a new start is required.
- State machine states and transitions:
  - IDLE: F_rtr=0. On start=1: H<=32'h811C9DC5, count<=0, go to WAIT. Byte, F_dr and End_of_File are ignored.
  - WAIT: F_rtr=1.
    - If End_of_File=1: go to LEN, len_idx<=0. EOF has priority over F_dr when both are high in the same cycle.
    - Else if F_dr=1: latch Byte, go to ABSORB.
    - Else stay in WAIT (no timeout; producer may stall indefinitely).
  - ABSORB (1 cycle, F_rtr=0):
    - H <= (H ^ {24'h0,byte_latched}) * 32'h01000193, mod 2^32.
    - count <= count+1, wrapping at 2^32.
    - Go to WAIT.
  - LEN (4 cycles, F_rtr=0): each cycle, H <= (H ^ {24'h0,count byte len_idx}) * 32'h01000193. Count bytes are taken LSB first (len_idx 0..3). Go to FMIX after len_idx=3.
  - FMIX (5 cycles, one step per cycle, F_rtr=0):
    1. H ^= H>>16
    2. H *= 32'h85EBCA6B
    3. H ^= H>>13
    4. H *= 32'hC2B2AE35
    5. H ^= H>>16
    - Then go to DONE.
  - DONE: H_ready=1, R_h=H, F_rtr=0. Held until reset; start, F_dr and End_of_File are ignored.
- R_h=0 in every state except DONE.
- start asserted in any state other than IDLE is ignored; it does not restart or disturb the hash.
- Handshake timing:
  - A byte is accepted at the edge where state=WAIT and F_dr=1 (EOF low).
  - F_rtr drops in the following cycle and returns high one cycle later.
  - Minimum 2 cycles per byte.
  - Producer need not deassert F_dr; if F_dr is still high when F_rtr returns, the current Byte is accepted again.
- Latency: EOF accepted at edge e → H_ready rises 9 cycles later (4 LEN + 5 FMIX).
- Empty message (start then EOF, no bytes): digest is the init value mixed with length 0 and finalized; valid, non-zero.
- Determinism: identical byte sequences give identical R_h across sessions and resets. Messages differing in length or content (e.g. "CiaoMondo" vs "CiaoMondo!") give different R_h.

Test Plan:
- Regular run: reset, start, send "CiaoMondo" (9 bytes) via F_dr/F_rtr, then EOF → F_rtr toggles 0/1 per byte, H_ready=1 exactly 9 cycles after EOF accept, R_h equals reference-model value; R_h=0 before H_ready.
- Reset mid-stream: reset asserted after byte k (k random 0..9), then restart and resend full "CiaoMondo" → F_rtr/H_ready/R_h go 0 on reset; final R_h identical to regular run.
- Spurious start: pulse start after byte k while in WAIT/ABSORB → ignored; R_h identical to regular run.
- Producer stall: hold F_dr=0 for 500 cycles before byte k → F_rtr stays 1 and state is preserved; R_h identical to regular run.
- Empty message: start then EOF only → H_ready after 9 cycles; R_h equals model value for length 0.
- Distinct inputs: "CiaoMondo" twice → equal R_h. "CiaoMondo" vs "CiaoMondo!" → different R_h. "CiaoMondo" vs "CiaoCiao!" → different R_h. EOF and F_dr high together in WAIT → treated as EOF only (count unchanged).

Source files
------------

// File: rtl/full_hash.sv
// full_hash: streaming byte hash (FNV-1a core, 32-bit length suffix, avalanche finalizer).
// Bytes arrive over an F_dr/F_rtr handshake; the digest is held on R_h once H_ready rises.
module full_hash (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  Byte,
    input  logic        End_of_File,
    input  logic        F_dr,
    output logic [0:31] R_h,
    output logic        F_rtr,
    output logic        H_ready
);
    localparam logic [31:0] fnv_init  = 32'h811C9DC5;
    localparam logic [31:0] fnv_prime = 32'h01000193;

    typedef enum logic [2:0] {IDLE, WAIT, ABSORB, LEN, FMIX, DONE} state_t;

    state_t      state, state_n;
    logic [31:0] h, h_n, count, count_n;
    logic [7:0]  byte_q, byte_n;
    logic [2:0]  idx, idx_n;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state  <= IDLE;
            h      <= '0;
            count  <= '0;
            byte_q <= '0;
            idx    <= '0;
        end else begin
            state  <= state_n;
            h      <= h_n;
            count  <= count_n;
            byte_q <= byte_n;
            idx    <= idx_n;
        end
    end

    // idx walks the four length bytes in LEN, then the five finalizer steps in FMIX
    always_comb begin
        state_n = state;
        h_n     = h;
        count_n = count;
        byte_n  = byte_q;
        idx_n   = idx;
        case (state)
            IDLE: if (start) begin
                h_n     = fnv_init;
                count_n = '0;
                state_n = WAIT;
            end
            WAIT: if (End_of_File) begin
                idx_n   = '0;
                state_n = LEN;
            end else if (F_dr) begin
                byte_n  = Byte;
                state_n = ABSORB;
            end
            ABSORB: begin
                h_n     = (h ^ {24'h0, byte_q}) * fnv_prime;
                count_n = count + 32'd1;
                state_n = WAIT;
            end
            LEN: begin
                h_n     = (h ^ {24'h0, count[8*idx[1:0] +: 8]}) * fnv_prime;
                idx_n   = (idx == 3'd3) ? 3'd0 : idx + 3'd1;
                state_n = (idx == 3'd3) ? FMIX : LEN;
            end
            FMIX: begin
                h_n     = (idx == 3'd0) ? h ^ (h >> 16) :
                          (idx == 3'd1) ? h * 32'h85EBCA6B :
                          (idx == 3'd2) ? h ^ (h >> 13) :
                          (idx == 3'd3) ? h * 32'hC2B2AE35 :
                                          h ^ (h >> 16);
                idx_n   = (idx == 3'd4) ? 3'd0 : idx + 3'd1;
                state_n = (idx == 3'd4) ? DONE : FMIX;
            end
            default: ;
        endcase
    end

    assign F_rtr   = (state == WAIT);
    assign H_ready = (state == DONE);
    assign R_h     = H_ready ? h : '0;
endmodule

// File: tb/tb_full_hash.sv
// tb_full_hash: directed sessions; the stimulus pushes reference digests, a monitor pops them on H_ready.
module tb_full_hash;
    logic        clk = 0, rst_n = 1, start = 0, End_of_File = 0, F_dr = 0;
    logic [7:0]  Byte = 0;
    logic [0:31] R_h;
    logic        F_rtr, H_ready;

    int          tests = 0, fails = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_digest = 0;
    logic        prev_ready = 0;

    always #5 clk = ~clk;

    full_hash dut (
        .clk(clk), .rst_n(rst_n), .start(start), .Byte(Byte),
        .End_of_File(End_of_File), .F_dr(F_dr),
        .R_h(R_h), .F_rtr(F_rtr), .H_ready(H_ready)
    );

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_diff(string name, logic [31:0] a, logic [31:0] b);
        tests++;
        if (a === b) begin
            fails++;
            $display("FAIL %s: got %h and %h, required different", name, a, b);
        end
    endtask

    function automatic logic [31:0] model(string s);
        logic [31:0] h = 32'h811C9DC5;
        int unsigned n = s.len();
        for (int i = 0; i < s.len(); i++) h = (h ^ {24'h0, s[i]}) * 32'h01000193;
        for (int j = 0; j < 4; j++) h = (h ^ ((n >> (8 * j)) & 32'hFF)) * 32'h01000193;
        h ^= h >> 16;
        h *= 32'h85EBCA6B;
        h ^= h >> 13;
        h *= 32'hC2B2AE35;
        h ^= h >> 16;
        return h;
    endfunction

    always @(negedge clk) begin
        if (H_ready && !prev_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_digest: got %h expected none", R_h);
            end else check("digest", R_h, exp_q.pop_front());
            last_digest = R_h;
        end
        prev_ready = H_ready;
    end

    task automatic do_reset;
        @(negedge clk);
        rst_n = 1; start = 0; F_dr = 0; End_of_File = 0;
        @(negedge clk);
        check("rst_rtr", {31'h0, F_rtr}, 0);
        check("rst_ready", {31'h0, H_ready}, 0);
        check("rst_rh", R_h, 0);
        rst_n = 0;
    endtask

    task automatic wait_rtr(string name);
        int n = 0;
        while (!F_rtr && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!F_rtr) check({name, "_rtr_timeout"}, {31'h0, F_rtr}, 1);
    endtask

    task automatic run_msg(string s, int stall_at, int spur_at, bit eof_dr, int abort_at,
                           output logic [31:0] dig);
        int lat;
        bit quiet = 1;
        dig = 0;
        do_reset();
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
        for (int i = 0; i < s.len(); i++) begin
            if (i == abort_at) begin
                do_reset();
                return;
            end
            wait_rtr("byte");
            if (i == stall_at) begin
                int low = 0;
                for (int c = 0; c < 500; c++) begin
                    @(negedge clk);
                    if (!F_rtr) low++;
                end
                check("stall_rtr_low_cycles", low, 0);
            end
            if (i == spur_at) begin
                start = 1;
                @(negedge clk);
                start = 0;
                check("spur_wait_rtr", {31'h0, F_rtr}, 1);
            end
            Byte = s[i]; F_dr = 1;
            @(negedge clk);
            check("absorb_rtr", {31'h0, F_rtr}, 0);
            if (i == spur_at) start = 1;
            F_dr = 0; Byte = 8'($urandom);
            @(negedge clk);
            start = 0;
            if (R_h !== 0) quiet = 0;
        end
        if (abort_at == s.len()) begin
            do_reset();
            return;
        end
        wait_rtr("eof");
        exp_q.push_back(model(s));
        End_of_File = 1;
        if (eof_dr) begin
            F_dr = 1;
            Byte = 8'h5A;
        end
        @(negedge clk);
        End_of_File = 0; F_dr = 0;
        lat = 0;
        while (!H_ready && lat < 40) begin
            if (R_h !== 0 || F_rtr) quiet = 0;
            @(negedge clk);
            lat++;
        end
        if (!H_ready) exp_q.delete();
        check("eof_latency", lat, 9);
        check("quiet_before_ready", {31'h0, quiet}, 1);
        @(negedge clk);
        dig = last_digest;
        start = 1;
        @(negedge clk);
        start = 0;
        @(negedge clk);
        check("done_hold_rh", R_h, model(s));
        check("done_hold_ready", {31'h0, H_ready}, 1);
    endtask

    initial begin
        logic [31:0] d_reg, d_again, d_bang, d_ciao, d_tmp;
        int k;
        run_msg("CiaoMondo", -1, -1, 0, -1, d_reg);
        k = $urandom_range(0, 9);
        run_msg("CiaoMondo", -1, -1, 0, k, d_tmp);
        run_msg("CiaoMondo", -1, -1, 0, -1, d_tmp);
        k = $urandom_range(0, 8);
        run_msg("CiaoMondo", -1, k, 0, -1, d_tmp);
        k = $urandom_range(0, 8);
        run_msg("CiaoMondo", k, -1, 0, -1, d_tmp);
        run_msg("", -1, -1, 0, -1, d_tmp);
        check_diff("empty_nonzero", d_tmp, 32'h0);
        run_msg("CiaoMondo", -1, -1, 0, -1, d_again);
        run_msg("CiaoMondo!", -1, -1, 0, -1, d_bang);
        run_msg("CiaoCiao!", -1, -1, 0, -1, d_ciao);
        check_diff("len_differs", d_again, d_bang);
        check_diff("content_differs", d_again, d_ciao);
        run_msg("CiaoMondo", -1, -1, 1, -1, d_tmp);
        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
